// File: rtl/gpio_sync_pkg.sv
// Shared definitions for the GPIO sync generator: FSM state encoding and
// default counter widths.
package gpio_sync_pkg;

   localparam int CNT_W_DEFAULT = 16;
   localparam int NP_W_DEFAULT  = 8;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_HIGH = 2'd1,
      ST_LOW  = 2'd2
   } state_t;

endpackage

// File: rtl/gpio_sync_period_cnt.sv
// Period counter for the sync generator: counts 0..period-1 while enabled and
// flags the end of the high phase and the end of the period.
module gpio_sync_period_cnt
   import gpio_sync_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             clear,
   input  logic             en,
   input  logic [CNT_W-1:0] period,
   input  logic [CNT_W-1:0] high_t,
   output logic             high_end,
   output logic             period_end
);

   logic [CNT_W-1:0] cnt;

   assign high_end   = (cnt == high_t - CNT_W'(1));
   assign period_end = (cnt == period - CNT_W'(1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt <= '0;
      end else if (clear) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= period_end ? '0 : cnt + CNT_W'(1);
      end
   end

endmodule

// File: rtl/gpio_sync_gen.sv
// GPIO sync pulse generator: finite or continuous square-wave bursts with
// trigger/done pulses. Define GPIO_SYNC_GEN_PCNT_EN to expose the pulse counter on PCNT.
module gpio_sync_gen
   import gpio_sync_pkg::*;
#(
   parameter int CNT_W = CNT_W_DEFAULT,
   parameter int NP_W  = NP_W_DEFAULT
) (
   input  logic             CLK,
   input  logic             RSET,
   input  logic             START,
   input  logic             STOP,
   input  logic [CNT_W-1:0] PERIOD,
   input  logic [CNT_W-1:0] HIGH_T,
   input  logic [NP_W-1:0]  NPULSE,
   output logic             SIG,
   output logic             TRIG,
   output logic             BUSY,
   output logic             DONE,
`ifdef GPIO_SYNC_GEN_PCNT_EN
   output logic             ERR,
   output logic [NP_W-1:0]  PCNT
`else
   output logic             ERR
`endif
);

   state_t           state, state_n;
   logic [CNT_W-1:0] period_q, high_q;
   logic [NP_W-1:0]  npulse_q, pcnt_q, pcnt_inc;
   logic             cfg_ok, start_ok, start_bad;
   logic             high_end, period_end, last_period, pcnt_step;
   logic             trig_n, done_n;

   assign cfg_ok    = (PERIOD >= CNT_W'(2)) && (HIGH_T != '0) && (HIGH_T < PERIOD);
   assign start_ok  = START && !STOP && (state == ST_IDLE) && cfg_ok;
   assign start_bad = START && !STOP && (state == ST_IDLE) && !cfg_ok;

   assign pcnt_inc    = pcnt_q + NP_W'(1);
   assign last_period = (npulse_q != '0) && (pcnt_inc == npulse_q);
   assign pcnt_step   = (state == ST_LOW) && !STOP && period_end;

   gpio_sync_period_cnt #(
      .CNT_W(CNT_W)
   ) u_period_cnt (
      .clk       (CLK),
      .rst       (RSET),
      .clear     (start_ok),
      .en        (state != ST_IDLE),
      .period    (period_q),
      .high_t    (high_q),
      .high_end  (high_end),
      .period_end(period_end)
   );

   // STOP takes priority over any phase or period transition
   always_comb begin
      state_n = state;
      trig_n  = 1'b0;
      done_n  = 1'b0;
      case (state)
         ST_IDLE: begin
            if (start_ok) begin
               state_n = ST_HIGH;
               trig_n  = 1'b1;
            end
         end
         ST_HIGH: begin
            if (STOP)          state_n = ST_IDLE;
            else if (high_end) state_n = ST_LOW;
         end
         ST_LOW: begin
            if (STOP) begin
               state_n = ST_IDLE;
            end else if (period_end) begin
               if (last_period) begin
                  state_n = ST_IDLE;
                  done_n  = 1'b1;
               end else begin
                  state_n = ST_HIGH;
                  trig_n  = 1'b1;
               end
            end
         end
         default: state_n = ST_IDLE;
      endcase
   end

   always_ff @(posedge CLK or posedge RSET) begin
      if (RSET) begin
         state    <= ST_IDLE;
         SIG      <= 1'b0;
         TRIG     <= 1'b0;
         BUSY     <= 1'b0;
         DONE     <= 1'b0;
         ERR      <= 1'b0;
         period_q <= '0;
         high_q   <= '0;
         npulse_q <= '0;
         pcnt_q   <= '0;
      end else begin
         state <= state_n;
         SIG   <= (state_n == ST_HIGH);
         BUSY  <= (state_n != ST_IDLE);
         TRIG  <= trig_n;
         DONE  <= done_n;
         if (start_ok) begin
            period_q <= PERIOD;
            high_q   <= HIGH_T;
            npulse_q <= NPULSE;
            pcnt_q   <= '0;
            ERR      <= 1'b0;
         end else begin
            if (start_bad) ERR <= 1'b1;
            if (pcnt_step) pcnt_q <= pcnt_inc;
         end
      end
   end

`ifdef GPIO_SYNC_GEN_PCNT_EN
   assign PCNT = pcnt_q;
`endif

endmodule

// File: tb/tb_gpio_sync_gen.sv
// Self-checking bench for gpio_sync_gen: burst-level reference model compared
// every cycle, plus directed scenarios with literal expectations.
module tb_gpio_sync_gen;

   localparam int CNT_W = 16;
   localparam int NP_W  = 8;

   logic             CLK = 1'b0;
   logic             RSET, START, STOP;
   logic [CNT_W-1:0] PERIOD, HIGH_T;
   logic [NP_W-1:0]  NPULSE;
   logic             SIG, TRIG, BUSY, DONE, ERR;
`ifdef GPIO_SYNC_GEN_PCNT_EN
   logic [NP_W-1:0]  PCNT;
`endif

   int vectors = 0;
   int miscompares = 0;

   always #5 CLK = ~CLK;

   gpio_sync_gen #(
      .CNT_W(CNT_W),
      .NP_W (NP_W)
   ) dut (
      .CLK   (CLK),
      .RSET  (RSET),
      .START (START),
      .STOP  (STOP),
      .PERIOD(PERIOD),
      .HIGH_T(HIGH_T),
      .NPULSE(NPULSE),
      .SIG   (SIG),
      .TRIG  (TRIG),
      .BUSY  (BUSY),
      .DONE  (DONE),
`ifdef GPIO_SYNC_GEN_PCNT_EN
      .ERR   (ERR),
      .PCNT  (PCNT)
`else
      .ERR   (ERR)
`endif
   );

   // Burst model: m_k is the 1-based cycle index inside the active burst.
   bit m_act, m_err, m_done;
   int m_k, m_p, m_h, m_n, m_hold;

   always @(posedge CLK or posedge RSET) begin
      if (RSET) begin
         m_act = 0; m_err = 0; m_done = 0;
         m_k = 0; m_p = 0; m_h = 0; m_n = 0; m_hold = 0;
      end else if (m_act) begin
         m_done = 0;
         if (STOP) begin
            m_hold = ((m_k - 1) / m_p) % (1 << NP_W);
            m_act  = 0;
         end else if (m_n != 0 && m_k + 1 == m_n * m_p + 1) begin
            m_hold = m_n;
            m_act  = 0;
            m_done = 1;
         end else begin
            m_k = m_k + 1;
         end
      end else begin
         m_done = 0;
         if (START && !STOP) begin
            if (int'(PERIOD) >= 2 && int'(HIGH_T) > 0 && int'(HIGH_T) < int'(PERIOD)) begin
               m_act = 1; m_k = 1; m_err = 0; m_hold = 0;
               m_p = int'(PERIOD); m_h = int'(HIGH_T); m_n = int'(NPULSE);
            end else begin
               m_err = 1;
            end
         end
      end
   end

   function automatic int pos_in_period();
      return (m_k - 1) % m_p;
   endfunction

   function automatic bit exp_sig();
      if (!m_act) return 0;
      return pos_in_period() < m_h;
   endfunction

   function automatic bit exp_trig();
      if (!m_act) return 0;
      return pos_in_period() == 0;
   endfunction

   function automatic int exp_pcnt();
      if (!m_act) return m_hold;
      return ((m_k - 1) / m_p) % (1 << NP_W);
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      vectors++;
      if (act !== exp) begin
         miscompares++;
         $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
      end
   endtask

   always @(negedge CLK) begin
      chk("model_sig",  32'(SIG),  32'(exp_sig()));
      chk("model_trig", 32'(TRIG), 32'(exp_trig()));
      chk("model_busy", 32'(BUSY), 32'(m_act));
      chk("model_done", 32'(DONE), 32'(m_done));
      chk("model_err",  32'(ERR),  32'(m_err));
`ifdef GPIO_SYNC_GEN_PCNT_EN
      chk("model_pcnt", 32'(PCNT), 32'(exp_pcnt()));
`endif
   end

   task automatic step(input int n);
      repeat (n) @(posedge CLK);
      #2;
   endtask

   task automatic go(input int p, input int h, input int n);
      START = 1'b1; STOP = 1'b0;
      PERIOD = CNT_W'(p); HIGH_T = CNT_W'(h); NPULSE = NP_W'(n);
      step(1);
      START = 1'b0;
   endtask

   logic [12:0] sig_l, trig_l, done_l, busy_l;
   logic [7:0]  sig4_l;

   initial begin
      RSET = 1'b1; START = 1'b0; STOP = 1'b0;
      PERIOD = '0; HIGH_T = '0; NPULSE = '0;
      step(2);
      chk("reset_sig",  32'(SIG),  0);
      chk("reset_busy", 32'(BUSY), 0);
      chk("reset_err",  32'(ERR),  0);
      chk("reset_done", 32'(DONE), 0);
      RSET = 1'b0;
      step(1);

      // finite burst P=4 H=2 N=3, cycles 1..13
      sig_l  = 13'b1100110011000;
      trig_l = 13'b1000100010000;
      done_l = 13'b0000000000001;
      busy_l = 13'b1111111111110;
      go(4, 2, 3);
      for (int c = 1; c <= 13; c++) begin
         @(negedge CLK);
         chk("burst_sig",  32'(SIG),  32'(sig_l[13-c]));
         chk("burst_trig", 32'(TRIG), 32'(trig_l[13-c]));
         chk("burst_done", 32'(DONE), 32'(done_l[13-c]));
         chk("burst_busy", 32'(BUSY), 32'(busy_l[13-c]));
      end
      step(2);

      // invalid configurations set ERR; valid start clears it
      go(5, 5, 1);
      chk("inv1_err",  32'(ERR),  1);
      chk("inv1_busy", 32'(BUSY), 0);
      go(1, 0, 1);
      chk("inv2_err",  32'(ERR),  1);
      chk("inv2_busy", 32'(BUSY), 0);
      go(6, 3, 1);
      chk("valid_err",  32'(ERR),  0);
      chk("valid_busy", 32'(BUSY), 1);
      step(8);

      // continuous mode, STOP during the sixth period
      go(3, 1, 0);
      step(16);
      STOP = 1'b1;
      step(1);
      STOP = 1'b0;
      chk("stop_sig",  32'(SIG),  0);
      chk("stop_busy", 32'(BUSY), 0);
      chk("stop_done", 32'(DONE), 0);
`ifdef GPIO_SYNC_GEN_PCNT_EN
      chk("stop_pcnt", 32'(PCNT), 5);
`endif
      step(1);
      chk("stop_done2", 32'(DONE), 0);

      // START+STOP together in IDLE does nothing
      START = 1'b1; STOP = 1'b1; PERIOD = 16'd4; HIGH_T = 16'd2;
      step(1);
      START = 1'b0; STOP = 1'b0;
      chk("ss_busy", 32'(BUSY), 0);
      chk("ss_sig",  32'(SIG),  0);

      // START while busy is ignored: period stays 4
      go(4, 2, 0);
      step(2);
      START = 1'b1; PERIOD = 16'd8; HIGH_T = 16'd6; NPULSE = 8'd1;
      step(1);
      START = 1'b0;
      sig4_l = 8'b01100110;
      for (int i = 0; i < 8; i++) begin
         @(negedge CLK);
         chk("restart_sig", 32'(SIG), 32'(sig4_l[7-i]));
      end
      step(1);
      STOP = 1'b1;
      step(1);
      STOP = 1'b0;

      // asynchronous reset during HIGH
      go(10, 5, 0);
      step(1);
      #1 RSET = 1'b1;
      #1;
      chk("arst_sig",  32'(SIG),  0);
      chk("arst_busy", 32'(BUSY), 0);
      chk("arst_trig", 32'(TRIG), 0);
      step(1);
      RSET = 1'b0;
      step(1);
      go(4, 2, 2);
      chk("post_rst_sig",  32'(SIG),  1);
      chk("post_rst_trig", 32'(TRIG), 1);
      step(10);

      // randomized traffic
      for (int i = 0; i < 3000; i++) begin
         if (RSET) RSET = 1'b0;
         else if ($urandom_range(0, 599) == 0) RSET = 1'b1;
         START  = ($urandom_range(0, 7) == 0);
         STOP   = ($urandom_range(0, 39) == 0);
         PERIOD = CNT_W'($urandom_range(0, 9));
         HIGH_T = CNT_W'($urandom_range(0, int'(PERIOD) + 1));
         NPULSE = ($urandom_range(0, 3) == 0) ? '0 : NP_W'($urandom_range(1, 4));
         step(1);
      end
      START = 1'b0; STOP = 1'b0; RSET = 1'b0;
      step(2);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
